seq_det_div: RTL and testbench

Parametrised serial pattern detector with a built-in sample-rate prescaler, all in a single clock domain. It replaces the derived divided clock with a one-cycle sample tick. The block samples ser_in once every DIV clocks and flags each occurrence of a PAT_W-bit pattern. The pattern is runtime-loadable, overlap/non-overlap mode is selectable at runtime, and matches are counted. It sits between a serial front-end and the control/status logic.

---
 rtl/seq_det_div.sv | 91 +++++++++
 tb/tb_seq_det_div.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_div.sv
// Serial pattern detector with an integrated sample-rate prescaler.
// ser_in is sampled once every DIV clocks; each PAT_W-bit match raises a one-clock pulse and is counted.
module seq_det_div #(
    parameter int                 DIV     = 3,
    parameter int                 PAT_W   = 4,
    parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    input  logic             clr_cnt,
    output logic             sample_tick,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [PAT_W-1:0]  shift_q, shift_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              tick;
    logic              hit;

    assign tick        = (div_cnt_q == DIV_LAST);
    assign sample_tick = tick;
    assign out         = out_q;
    assign match_cnt   = cnt_q;

    always_comb begin
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        shift_d   = shift_q;
        pattern_d = pattern_q;
        fill_d    = fill_q;
        fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        hit       = 1'b0;

        // A pattern load restarts the window and swallows any coincident sample.
        if (pat_load) begin
            pattern_d = pat_in;
            shift_d   = '0;
            fill_d    = '0;
        end else if (tick) begin
            shift_d = {shift_q[PAT_W-2:0], ser_in};
            fill_d  = fill_inc;
            hit     = (fill_inc == FILL_FULL) && (shift_d == pattern_q);
            if (hit && !overlap_en) begin
                fill_d = '0;
            end
        end

        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        out_d = hit;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q <= '0;
            shift_q   <= '0;
            pattern_q <= PATTERN;
            fill_q    <= '0;
            cnt_q     <= '0;
            out_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            shift_q   <= shift_d;
            pattern_q <= pattern_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
        end
    end

endmodule

// File: tb/tb_seq_det_div.sv
// Directed testbench for seq_det_div: prescaler, overlap modes, pattern load,
// counter saturation/clear and mid-stream reset, using three parameterisations.
module tb_seq_det_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_in;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       overlap_en;
    logic       clr_cnt;

    logic       tick_m, out_m;
    logic [7:0] cnt_m;
    logic       tick_1, out_1;
    logic [7:0] cnt_1;
    logic       tick_s, out_s;
    logic [1:0] cnt_s;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seq_det_div #(.DIV(3), .PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ser_in(ser_in), .pat_load(pat_load), .pat_in(pat_in),
        .overlap_en(overlap_en), .clr_cnt(clr_cnt),
        .sample_tick(tick_m), .out(out_m), .match_cnt(cnt_m)
    );

    seq_det_div #(.DIV(1), .PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_div1 (
        .clk(clk), .rst(rst), .ser_in(ser_in), .pat_load(pat_load), .pat_in(pat_in),
        .overlap_en(overlap_en), .clr_cnt(clr_cnt),
        .sample_tick(tick_1), .out(out_1), .match_cnt(cnt_1)
    );

    seq_det_div #(.DIV(3), .PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .ser_in(ser_in), .pat_load(pat_load), .pat_in(pat_in),
        .overlap_en(overlap_en), .clr_cnt(clr_cnt),
        .sample_tick(tick_s), .out(out_s), .match_cnt(cnt_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        rst = 1'b1;
    endtask

    // Waits (bounded) for a tick cycle, presents one bit, and returns the post-edge out values.
    task automatic send_bit(input logic b, input logic clr, output logic o_main, output logic o_sat);
        for (int i = 0; i < 8 && !tick_m; i++) step();
        if (!tick_m) begin
            tests_run++;
            tests_failed++;
            $display("FAIL tick_timeout: sample_tick=%0b required 1", tick_m);
        end
        ser_in  = b;
        clr_cnt = clr;
        step();
        clr_cnt = 1'b0;
        o_main  = out_m;
        o_sat   = out_s;
        $display("[TB] bit=%0b out=%0b cnt=%0d out_sat=%0b cnt_sat=%0d", b, o_main, cnt_m, o_sat, cnt_s);
    endtask

    task automatic send_stream(input string name, input logic [15:0] bits,
                               input logic [15:0] exp_pulse, input int n);
        logic om, os;
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i], 1'b0, om, os);
            tests_run++;
            if (om !== exp_pulse[i]) begin
                tests_failed++;
                $display("FAIL %s_pulse[%0d]: out=%0b required %0b", name, n - 1 - i, om, exp_pulse[i]);
            end
            if (om) begin
                step();
                tests_run++;
                if (out_m !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s_width[%0d]: out=%0b required 0", name, n - 1 - i, out_m);
                end
            end
        end
    endtask

    task automatic test_reset();
        int exp_tick;
        do_reset(2);
        tests_run++;
        if (out_m !== 1'b0 || cnt_m !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_state: out=%0b cnt=%0d required 0 0", out_m, cnt_m);
        end
        for (int c = 1; c <= 9; c++) begin
            exp_tick = (c % 3 == 0) ? 1 : 0;
            tests_run++;
            if (tick_m !== 1'(exp_tick)) begin
                tests_failed++;
                $display("FAIL prescaler_clk%0d: sample_tick=%0b required %0d", c, tick_m, exp_tick);
            end
            tests_run++;
            if (tick_1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL div1_tick_clk%0d: sample_tick=%0b required 1", c, tick_1);
            end
            step();
        end
    endtask

    task automatic test_overlap();
        do_reset(1);
        overlap_en = 1'b1;
        send_stream("overlap", 16'b1011011, 16'b0001001, 7);
        tests_run++;
        if (cnt_m !== 8'd2) begin
            tests_failed++;
            $display("FAIL overlap_cnt: match_cnt=%0d required 2", cnt_m);
        end
    endtask

    task automatic test_non_overlap();
        do_reset(1);
        overlap_en = 1'b0;
        send_stream("nonoverlap", 16'b1011011, 16'b0001000, 7);
        tests_run++;
        if (cnt_m !== 8'd1) begin
            tests_failed++;
            $display("FAIL nonoverlap_cnt: match_cnt=%0d required 1", cnt_m);
        end
        overlap_en = 1'b1;
    endtask

    task automatic test_pattern_load();
        do_reset(1);
        overlap_en = 1'b1;
        send_stream("load_pre", 16'b10, 16'b00, 2);
        for (int i = 0; i < 8 && !tick_m; i++) step();
        pat_load = 1'b1;
        pat_in   = 4'b0110;
        ser_in   = 1'b1;
        step();
        pat_load = 1'b0;
        tests_run++;
        if (out_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_tick_out: out=%0b required 0", out_m);
        end
        send_stream("load_post", 16'b110110, 16'b000001, 6);
        tests_run++;
        if (cnt_m !== 8'd1) begin
            tests_failed++;
            $display("FAIL load_cnt: match_cnt=%0d required 1", cnt_m);
        end
    endtask

    task automatic test_saturation_clear();
        logic om, os;
        do_reset(1);
        overlap_en = 1'b1;
        send_stream("sat", 16'b1011011011011011, 16'b0001001001001001, 16);
        tests_run++;
        if (cnt_s !== 2'd3) begin
            tests_failed++;
            $display("FAIL sat_cnt: match_cnt=%0d required 3", cnt_s);
        end
        send_bit(1'b0, 1'b0, om, os);
        send_bit(1'b1, 1'b0, om, os);
        tests_run++;
        if (cnt_s !== 2'd3) begin
            tests_failed++;
            $display("FAIL sat_hold: match_cnt=%0d required 3", cnt_s);
        end
        send_bit(1'b1, 1'b1, om, os);
        tests_run++;
        if (os !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_hit_out: out=%0b required 1", os);
        end
        tests_run++;
        if (cnt_s !== 2'd0) begin
            tests_failed++;
            $display("FAIL clr_hit_cnt: match_cnt=%0d required 0", cnt_s);
        end
    endtask

    task automatic test_midstream_reset();
        do_reset(1);
        overlap_en = 1'b1;
        send_stream("rst_pre", 16'b101, 16'b000, 3);
        do_reset(1);
        send_stream("rst_post", 16'b11011, 16'b00001, 5);
        tests_run++;
        if (cnt_m !== 8'd1) begin
            tests_failed++;
            $display("FAIL rst_cnt: match_cnt=%0d required 1", cnt_m);
        end
    endtask

    initial begin
        rst        = 1'b0;
        ser_in     = 1'b0;
        pat_load   = 1'b0;
        pat_in     = 4'b0000;
        overlap_en = 1'b1;
        clr_cnt    = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_pattern_load();
        test_saturation_clear();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
